// File: rtl/rs_pkg.sv
// rs_pkg: shared types and helpers for the reservation station.
//   rs_uop_t     renamed uop as held in an entry and presented at issue
//   sqn_older    wrap-around age compare: a is older than b
//   sqn_younger  wrap-around age compare: a is strictly younger than b
package rs_pkg;

    localparam int TAG_W     = 6;
    localparam int SQN_W     = 6;
    localparam int PAYLOAD_W = 16;

    typedef struct packed {
        logic [TAG_W-1:0]     tagA;
        logic                 availA;
        logic [TAG_W-1:0]     tagB;
        logic                 availB;
        logic [TAG_W-1:0]     tagDst;
        logic [SQN_W-1:0]     sqN;
        logic [PAYLOAD_W-1:0] payload;
    } rs_uop_t;

    // $signed(a - b) < 0 on the SQN_W-bit ring.
    function automatic logic sqn_older(input logic [SQN_W-1:0] a,
                                       input logic [SQN_W-1:0] b);
        logic [SQN_W-1:0] diff;
        diff = a - b;
        return diff[SQN_W-1];
    endfunction

    // $signed(a - b) > 0 on the SQN_W-bit ring.
    function automatic logic sqn_younger(input logic [SQN_W-1:0] a,
                                         input logic [SQN_W-1:0] b);
        logic [SQN_W-1:0] diff;
        diff = a - b;
        return (diff != '0) && !diff[SQN_W-1];
    endfunction

endpackage

// File: rtl/rs_age_select.sv
// rs_age_select: combinational oldest-ready picker.
//   ready  in  per-entry "both operands available" bits
//   sqn    in  per-entry sequence numbers
//   grant  out one-hot grant of the oldest ready entry
//   found  out at least one entry is ready
module rs_age_select
    import rs_pkg::*;
#(
    parameter int NUM_ENTRIES = 8
) (
    input  logic [NUM_ENTRIES-1:0]            ready,
    input  logic [NUM_ENTRIES-1:0][SQN_W-1:0] sqn,
    output logic [NUM_ENTRIES-1:0]            grant,
    output logic                              found
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
            // Entry gi wins when it is older than every other ready entry;
            // live sequence numbers are unique, so at most one entry wins.
            logic [NUM_ENTRIES-1:0] beats;
            always_comb begin
                for (int j = 0; j < NUM_ENTRIES; j++) begin
                    beats[j] = (j == gi) || !ready[j] || sqn_older(sqn[gi], sqn[j]);
                end
            end
            assign grant[gi] = ready[gi] && (&beats);
        end
    endgenerate

    assign found = |ready;

endmodule

// File: rtl/issue_queue.sv
// issue_queue: reservation station between rename and one execution unit.
//   IN_uopValid/IN_uop     up to WIDTH_IN renamed uops per cycle
//   IN_wbValid/IN_wbTag    writeback buses snooped for operand wakeup
//   IN_branchTaken/SqN     flush of everything younger than the branch
//   IN_issueReady          execution unit accepts OUT_issue
//   OUT_issueValid/issue   registered oldest-ready uop
//   OUT_stall/freeCount    free-entry status from registered valid bits
module issue_queue
    import rs_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int WIDTH_IN    = 2,
    parameter int WIDTH_WB    = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [WIDTH_IN-1:0]               IN_uopValid,
    input  rs_uop_t [WIDTH_IN-1:0]            IN_uop,
    input  logic [WIDTH_WB-1:0]               IN_wbValid,
    input  logic [WIDTH_WB-1:0][TAG_W-1:0]    IN_wbTag,
    input  logic                              IN_branchTaken,
    input  logic [SQN_W-1:0]                  IN_branchSqN,
    input  logic                              IN_issueReady,
    output logic                              OUT_issueValid,
    output rs_uop_t                           OUT_issue,
    output logic                              OUT_stall,
    output logic [$clog2(NUM_ENTRIES):0]      OUT_freeCount
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = IDX_W + 1;

    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    rs_uop_t                entry_q [NUM_ENTRIES];
    rs_uop_t                entry_d [NUM_ENTRIES];
    logic                   issue_valid_q, issue_valid_d;
    rs_uop_t                issue_q, issue_d;

    logic [NUM_ENTRIES-1:0]            entry_ready, wake_a, wake_b, grant;
    logic [NUM_ENTRIES-1:0][SQN_W-1:0] entry_sqn;
    logic                              found;
    rs_uop_t                           sel_uop;
    rs_uop_t [WIDTH_IN-1:0]            in_snoop;
    logic [WIDTH_IN-1:0]               alloc_hit;
    logic [WIDTH_IN-1:0][IDX_W-1:0]    alloc_idx;
    logic [NUM_ENTRIES-1:0]            taken;
    logic [CNT_W-1:0]                  free_count;

    function automatic logic wb_hit(input logic [TAG_W-1:0]               tag,
                                    input logic [WIDTH_WB-1:0]            v,
                                    input logic [WIDTH_WB-1:0][TAG_W-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < WIDTH_WB; k++) begin
            if (v[k] && tags[k] == tag) hit = 1'b1;
        end
        return hit;
    endfunction

    // Readiness uses registered avail bits, so a wakeup becomes selectable
    // one cycle after the writeback is seen.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
            assign entry_ready[gi] = valid_q[gi] && entry_q[gi].availA && entry_q[gi].availB;
            assign entry_sqn[gi]   = entry_q[gi].sqN;
            assign wake_a[gi]      = wb_hit(entry_q[gi].tagA, IN_wbValid, IN_wbTag);
            assign wake_b[gi]      = wb_hit(entry_q[gi].tagB, IN_wbValid, IN_wbTag);
        end
    endgenerate

    rs_age_select #(
        .NUM_ENTRIES(NUM_ENTRIES)
    ) u_select (
        .ready (entry_ready),
        .sqn   (entry_sqn),
        .grant (grant),
        .found (found)
    );

    always_comb begin
        sel_uop = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (grant[i]) sel_uop = entry_q[i];
        end
    end

    // Incoming uops snoop the same-cycle writeback buses.
    always_comb begin
        for (int w = 0; w < WIDTH_IN; w++) begin
            in_snoop[w] = IN_uop[w];
            if (wb_hit(IN_uop[w].tagA, IN_wbValid, IN_wbTag)) in_snoop[w].availA = 1'b1;
            if (wb_hit(IN_uop[w].tagB, IN_wbValid, IN_wbTag)) in_snoop[w].availB = 1'b1;
        end
    end

    // Valid slots take successive lowest-index free entries. Only entries free
    // at the start of the cycle count, so one freed by this cycle's issue is
    // not reused until the next cycle. Slots finding no free entry are dropped.
    always_comb begin
        taken     = '0;
        alloc_hit = '0;
        alloc_idx = '0;
        for (int w = 0; w < WIDTH_IN; w++) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (IN_uopValid[w] && !alloc_hit[w] && !valid_q[i] && !taken[i]) begin
                    alloc_hit[w] = 1'b1;
                    alloc_idx[w] = IDX_W'(i);
                    taken[i]     = 1'b1;
                end
            end
        end
    end

    always_comb begin
        valid_d       = valid_q;
        entry_d       = entry_q;
        issue_valid_d = issue_valid_q;
        issue_d       = issue_q;

        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (wake_a[i]) entry_d[i].availA = 1'b1;
            if (wake_b[i]) entry_d[i].availB = 1'b1;
        end

        if (IN_branchTaken) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (sqn_younger(entry_q[i].sqN, IN_branchSqN)) valid_d[i] = 1'b0;
            end
            // An accepted uop leaves either way; a held younger one is killed.
            if (issue_valid_q &&
                (IN_issueReady || sqn_younger(issue_q.sqN, IN_branchSqN))) begin
                issue_valid_d = 1'b0;
                issue_d       = '0;
            end
        end else begin
            if (!issue_valid_q || IN_issueReady) begin
                issue_valid_d = found;
                issue_d       = sel_uop;
                valid_d       = valid_d & ~grant;
            end
            for (int w = 0; w < WIDTH_IN; w++) begin
                if (alloc_hit[w]) begin
                    valid_d[alloc_idx[w]] = 1'b1;
                    entry_d[alloc_idx[w]] = in_snoop[w];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= '0;
            issue_valid_q <= 1'b0;
            issue_q       <= '0;
        end else begin
            valid_q       <= valid_d;
            issue_valid_q <= issue_valid_d;
            issue_q       <= issue_d;
        end
    end

    // Payload storage needs no reset: every read is qualified by valid_q.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

    always_comb begin
        free_count = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            free_count = free_count + CNT_W'(!valid_q[i]);
        end
    end

    assign OUT_freeCount  = free_count;
    assign OUT_stall      = free_count < CNT_W'(WIDTH_IN);
    assign OUT_issueValid = issue_valid_q;
    assign OUT_issue      = issue_q;

endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed plus randomized stimulus against a queue-based
// reference model; issued uops are checked through a scoreboard by a
// monitor sampling on the falling clock edge.
module tb_issue_queue;
    import rs_pkg::*;

    localparam int N  = 8;
    localparam int WI = 2;
    localparam int WB = 3;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [WI-1:0]               in_valid;
    rs_uop_t [WI-1:0]            in_uop;
    logic [WB-1:0]               wb_valid;
    logic [WB-1:0][TAG_W-1:0]    wb_tag;
    logic                        br;
    logic [SQN_W-1:0]            br_sqn;
    logic                        iss_ready;
    logic                        out_valid;
    rs_uop_t                     out_issue;
    logic                        out_stall;
    logic [3:0]                  out_free;

    always #5 clk = ~clk;

    issue_queue #(.NUM_ENTRIES(N), .WIDTH_IN(WI), .WIDTH_WB(WB)) dut (
        .clk(clk), .rst(rst),
        .IN_uopValid(in_valid), .IN_uop(in_uop),
        .IN_wbValid(wb_valid), .IN_wbTag(wb_tag),
        .IN_branchTaken(br), .IN_branchSqN(br_sqn),
        .IN_issueReady(iss_ready),
        .OUT_issueValid(out_valid), .OUT_issue(out_issue),
        .OUT_stall(out_stall), .OUT_freeCount(out_free)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending uops as an unordered list plus the issue slot.
    rs_uop_t          m_q[$];
    logic             m_reg_v = 1'b0;
    rs_uop_t          m_reg   = '0;
    rs_uop_t          exp_q[$];
    logic             exp_valid = 1'b0;
    rs_uop_t          exp_reg   = '0;
    int               exp_free  = N;
    logic [SQN_W-1:0] got_sqn[$];
    logic             mon_en   = 1'b0;
    int               next_sqn = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit m_wb(input logic [TAG_W-1:0] t);
        for (int k = 0; k < WB; k++) if (wb_valid[k] && wb_tag[k] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_older(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
        int d;
        d = (int'(a) - int'(b)) & 63;
        return d >= 32;
    endfunction

    function automatic bit m_after(input logic [SQN_W-1:0] s, input logic [SQN_W-1:0] b);
        int d;
        d = (int'(s) - int'(b)) & 63;
        return d >= 1 && d <= 31;
    endfunction

    function automatic int max_age();
        int a;
        int d;
        a = 0;
        foreach (m_q[i]) begin
            d = (next_sqn - int'(m_q[i].sqN)) & 63;
            if (d > a) a = d;
        end
        if (m_reg_v) begin
            d = (next_sqn - int'(m_reg.sqN)) & 63;
            if (d > a) a = d;
        end
        return a;
    endfunction

    function automatic rs_uop_t mk(input int sqn, input int ta, input bit aa, input int tb, input bit ab);
        rs_uop_t u;
        u.tagA    = TAG_W'(ta);
        u.availA  = aa;
        u.tagB    = TAG_W'(tb);
        u.availB  = ab;
        u.tagDst  = TAG_W'(sqn + 7);
        u.sqN     = SQN_W'(sqn);
        u.payload = PAYLOAD_W'(sqn * 257 + 3);
        return u;
    endfunction

    // Advance the model across one clock edge using the inputs just sampled.
    task automatic model_update();
        int      base;
        int      added;
        int      best;
        rs_uop_t u;
        if (rst) begin
            m_q.delete();
            m_reg_v = 1'b0;
            m_reg   = '0;
            return;
        end
        base  = m_q.size();
        added = 0;
        if (br) begin
            if (m_reg_v && (iss_ready || m_after(m_reg.sqN, br_sqn))) m_reg_v = 1'b0;
            for (int i = m_q.size() - 1; i >= 0; i--) begin
                if (m_after(m_q[i].sqN, br_sqn)) m_q.delete(i);
            end
        end else if (!m_reg_v || iss_ready) begin
            best = -1;
            foreach (m_q[i]) begin
                if (m_q[i].availA && m_q[i].availB &&
                    (best < 0 || m_older(m_q[i].sqN, m_q[best].sqN))) best = i;
            end
            m_reg_v = (best >= 0);
            if (best >= 0) begin
                m_reg = m_q[best];
                m_q.delete(best);
            end
        end
        foreach (m_q[i]) begin
            u = m_q[i];
            if (m_wb(u.tagA)) u.availA = 1'b1;
            if (m_wb(u.tagB)) u.availB = 1'b1;
            m_q[i] = u;
        end
        if (!br) begin
            for (int w = 0; w < WI; w++) begin
                if (in_valid[w] && base + added < N) begin
                    u = in_uop[w];
                    if (m_wb(u.tagA)) u.availA = 1'b1;
                    if (m_wb(u.tagB)) u.availB = 1'b1;
                    m_q.push_back(u);
                    added++;
                end
            end
        end
    endtask

    // One clock cycle: inputs are already driven by the caller.
    task automatic step();
        if (!rst && !br) begin
            int n;
            n = 0;
            for (int w = 0; w < WI; w++) n += int'(in_valid[w]);
            if (n > N - m_q.size()) begin
                n_fail++;
                $display("FAIL enq_overflow: %0d uops offered, %0d free", n, N - m_q.size());
            end
        end
        if (!rst && m_reg_v && iss_ready) exp_q.push_back(m_reg);
        @(posedge clk);
        #1;
        model_update();
        exp_valid = m_reg_v;
        exp_reg   = m_reg;
        exp_free  = N - m_q.size();
        in_valid  = '0;
        wb_valid  = '0;
        br        = 1'b0;
    endtask

    task automatic check_order(input string name, input int n, input int e0, input int e1,
                               input int e2, input int e3);
        int e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        check({name, "_count"}, got_sqn.size(), n);
        for (int i = 0; i < n && i < got_sqn.size(); i++) check(name, int'(got_sqn[i]), e[i]);
    endtask

    // Monitor: scalar outputs every cycle, issued uops via the scoreboard.
    initial begin
        rs_uop_t e;
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                check("issue_valid", int'(out_valid), int'(exp_valid));
                check("free_count", int'(out_free), exp_free);
                check("stall", int'(out_stall), int'(exp_free < WI));
                if (exp_valid) check_vec("issue_hold", 64'(out_issue), 64'(exp_reg));
                if (out_valid && iss_ready) begin
                    if (exp_q.size() == 0) begin
                        check_vec("transfer_unexpected", 64'(out_issue), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check_vec("transfer", 64'(out_issue), 64'(e));
                    end
                    got_sqn.push_back(out_issue.sqN);
                    $display("[TB] t=%0t issue sqN=%0d payload=%h", $time, out_issue.sqN, out_issue.payload);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rs_uop_t t6;
        rst = 1'b1; in_valid = '0; in_uop = '0; wb_valid = '0; wb_tag = '0;
        br = 1'b0; br_sqn = '0; iss_ready = 1'b1;
        step(); step();
        rst = 1'b0; mon_en = 1'b1;

        // Reset state
        check("rst_valid", int'(out_valid), 0);
        check_vec("rst_issue", 64'(out_issue), 64'(0));
        check("rst_free", int'(out_free), N);
        check("rst_stall", int'(out_stall), 0);

        // T1: two-cycle latency
        got_sqn.delete();
        in_valid = 2'b01; in_uop[0] = mk(0, 1, 1, 2, 1);
        step();
        check("t1_not_early", int'(out_valid), 0);
        step();
        check("t1_valid", int'(out_valid), 1);
        check("t1_sqn", int'(out_issue.sqN), 0);
        step(); step();
        check_order("t1_order", 1, 0, 0, 0, 0);
        check("t1_free", int'(out_free), N);

        // T2: wakeup reorders issue
        got_sqn.delete();
        in_valid = 2'b11; in_uop[0] = mk(3, 40, 0, 41, 1); in_uop[1] = mk(4, 42, 1, 43, 1);
        step();
        wb_valid = 3'b001; wb_tag[0] = 6'd40;
        step(); step(); step(); step();
        check_order("t2_order", 2, 4, 3, 0, 0);

        // T3: wrap-around age compare
        got_sqn.delete();
        in_valid = 2'b11; in_uop[0] = mk(62, 1, 1, 2, 1); in_uop[1] = mk(63, 1, 1, 2, 1);
        step();
        in_valid = 2'b11; in_uop[0] = mk(0, 1, 1, 2, 1); in_uop[1] = mk(1, 1, 1, 2, 1);
        step();
        for (int k = 0; k < 6; k++) step();
        check_order("t3_order", 4, 62, 63, 0, 1);

        // T4: full queue, stall release, then mid-operation reset
        for (int k = 0; k < 3; k++) begin
            in_valid = 2'b11;
            in_uop[0] = mk(10 + 2 * k, 20 + 2 * k, 0, 1, 1);
            in_uop[1] = mk(11 + 2 * k, 21 + 2 * k, 0, 1, 1);
            step();
        end
        in_valid = 2'b01; in_uop[0] = mk(16, 26, 0, 1, 1);
        step();
        check("t4_full_free", int'(out_free), 1);
        check("t4_full_stall", int'(out_stall), 1);
        wb_valid = 3'b010; wb_tag[1] = 6'd20;
        step();
        check("t4_stall_hold", int'(out_stall), 1);
        step();
        check("t4_stall_clear", int'(out_stall), 0);
        check("t4_free_after", int'(out_free), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t4_rst_free", int'(out_free), N);
        check("t4_rst_valid", int'(out_valid), 0);

        // T5: flush discards younger entries and same-cycle enqueue
        in_valid = 2'b11; in_uop[0] = mk(10, 30, 0, 1, 1); in_uop[1] = mk(12, 31, 0, 1, 1);
        step();
        in_valid = 2'b01; in_uop[0] = mk(14, 32, 0, 1, 1);
        step();
        check("t5_pre_free", int'(out_free), 5);
        br = 1'b1; br_sqn = 6'd11;
        in_valid = 2'b01; in_uop[0] = mk(15, 1, 1, 2, 1);
        step();
        check("t5_free", int'(out_free), 7);
        rst = 1'b1;
        step();
        rst = 1'b0;

        // T6: back-pressure holds the issue register stable
        got_sqn.delete();
        iss_ready = 1'b0;
        t6 = mk(20, 5, 1, 6, 1);
        in_valid = 2'b01; in_uop[0] = t6;
        step(); step();
        check("t6_valid", int'(out_valid), 1);
        for (int k = 0; k < 3; k++) begin
            check_vec("t6_hold", 64'(out_issue), 64'(t6));
            step();
        end
        check_vec("t6_hold_last", 64'(out_issue), 64'(t6));
        check("t6_not_released", got_sqn.size(), 0);
        iss_ready = 1'b1;
        step();
        check_order("t6_order", 1, 20, 0, 0, 0);
        step(); step();

        // Randomized phase
        next_sqn = 21;
        for (int c = 0; c < 1500; c++) begin
            iss_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < WB; k++) begin
                wb_valid[k] = ($urandom_range(0, 1) == 1);
                wb_tag[k]   = TAG_W'($urandom_range(0, 15));
            end
            br = ($urandom_range(0, 31) == 0);
            if (br) br_sqn = SQN_W'(next_sqn - 1 - int'($urandom_range(0, 4)));
            in_valid = '0;
            if ((N - m_q.size()) >= WI && max_age() < 20) begin
                for (int w = 0; w < WI; w++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        in_valid[w] = 1'b1;
                        in_uop[w] = mk(next_sqn, int'($urandom_range(0, 15)), ($urandom_range(0, 1) == 1),
                                       int'($urandom_range(0, 15)), ($urandom_range(0, 1) == 1));
                        in_uop[w].payload = PAYLOAD_W'($urandom);
                        next_sqn = (next_sqn + 1) & 63;
                    end
                end
            end
            if (br) next_sqn = (int'(br_sqn) + 1) & 63;
            rst = ($urandom_range(0, 399) == 0);
            step();
            rst = 1'b0;
        end
        iss_ready = 1'b1;
        step(); step();
        check("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
# issue_queue

Reservation station directly downstream of the rename stage. It accepts up to two renamed uops per cycle and holds them until both source operands are available. Operand tags are woken up by snooping the writeback buses. Each cycle it issues the oldest ready uop, by sequence number, to one execution unit through a valid/ready handshake, and it discards younger-than-branch entries on a taken branch.

## Interface
Parameters:
- NUM_ENTRIES, 8, queue depth (power of two, ≥ 4)
- WIDTH_IN, 2, uops accepted per cycle
- WIDTH_WB, 3, writeback buses snooped

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- IN_uopValid  in  WIDTH_IN  per-slot valid from rename
- IN_uop  in  WIDTH_IN × rs_uop_t  renamed uop: tagA, availA, tagB, availB, tagDst, sqN (6 b each tag/sqN), payload
- IN_wbValid  in  WIDTH_WB  writeback result valid
- IN_wbTag  in  WIDTH_WB × 6  writeback destination tag
- IN_branchTaken  in  1  mispredict flush request
- IN_branchSqN  in  6  sqN of the mispredicted branch
- IN_issueReady  in  1  execution unit accepts OUT_issue this cycle
- OUT_issueValid  out  1  OUT_issue holds a uop
- OUT_issue  out  rs_uop_t  issued uop
- OUT_stall  out  1  fewer than WIDTH_IN free entries; rename must hold
- OUT_freeCount  out  $clog2(NUM_ENTRIES)+1  number of free entries

## Operation
- Entry state: valid bit plus an rs_uop_t. availA/availB are kept per entry.
- Enqueue:
  - Each valid input slot is written to the lowest-index free entry. Slot 0 takes the lowest index, slot 1 the next.
  - Input uops are written even if IN_uopValid is set while OUT_stall=1, but only while free entries remain. Any excess is dropped, and the bench flags this as an assertion.
- Wakeup:
  - A valid entry with tagX == IN_wbTag[k] and IN_wbValid[k] sets availX.
  - An enqueuing uop snoops the same-cycle writeback buses, so the write stores availX=1 on a match.
- Select:
  - Among valid entries with availA && availB, pick the one with minimal age, i.e. entry a beats b iff $signed(a.sqN − b.sqN) < 0 (6-bit wrap-around compare).
  - Ties cannot occur.
- Issue register:
  - It is loaded with the selected uop, and the entry is freed in the same edge, when the register is empty or IN_issueReady=1.
  - Otherwise the register holds and no entry is freed.
- Flush (IN_branchTaken=1):
  - Every entry with $signed(sqN − IN_branchSqN) > 0 is invalidated.
  - The issue register is cleared if it holds such a uop.
  - All enqueues that cycle are ignored and no new selection is loaded.
  - Wakeups still apply to surviving entries.
- OUT_stall and OUT_freeCount are combinational from the registered valid bits only.

## Timing
- Reset:
  - All entries invalid.
  - OUT_issueValid=0, OUT_issue=0.
  - OUT_freeCount=NUM_ENTRIES, OUT_stall=0.
  - Reset asserted mid-operation discards everything on that edge.
- Latency:
  - Uop enqueued at edge N with both operands available appears on OUT_issueValid in the cycle after edge N+1 (two-cycle minimum).
  - Wakeup seen in cycle M makes the entry selectable in cycle M+1.
- Handshake: the transfer occurs on an edge where OUT_issueValid && IN_issueReady. OUT_issue is stable while valid and not accepted.
- Full queue: OUT_stall=1 when OUT_freeCount < WIDTH_IN. An issue in the same cycle does not clear the stall until the next cycle.
- Simultaneous enqueue and issue: allowed. A freed entry is reusable only from the next cycle.
- Flush and IN_issueReady in the same cycle: flush takes priority for the register contents; an accepted uop older than the branch completes.

## Structure
- Shared package rs_pkg:
  - rs_uop_t packed struct.
  - TAG_W=6, SQN_W=6.
  - Function sqn_older(a,b) for the wrap-around compare.
- Sub-module rs_age_select: combinational oldest-ready picker over NUM_ENTRIES. Inputs are ready bits and sqNs; outputs are a one-hot grant and a found flag.
- Top holds entry storage, wakeup, free-slot allocation, flush logic and the issue register.

## Test plan
- Reset, then enqueue sqN 0 (availA=availB=1) -> OUT_issueValid=1 with sqN 0 two cycles later; OUT_freeCount returns to 8.
- Enqueue sqN 3 (tagA 40 unavailable) and sqN 4 (ready); wb tag 40 in the next cycle -> sqN 4 issues first, sqN 3 one cycle after it.
- Enqueue sqN 62, 63, 0, 1, all ready, with IN_issueReady=1 -> issue order 62, 63, 0, 1 (wrap-around).
- Fill 7 entries with unready uops -> OUT_stall=1, OUT_freeCount=1. Wake one entry and issue it -> OUT_stall=0 the cycle after the issue edge.
- Entries sqN 10, 12, 14; IN_branchTaken with IN_branchSqN=11 plus a same-cycle enqueue of sqN 15 -> only sqN 10 survives, OUT_freeCount=7.
- Hold IN_issueReady=0 for 3 cycles with OUT_issueValid=1 -> OUT_issue unchanged; the uop is released on the first ready cycle.
